// File: rtl/fft_pkg.sv
// fft_pkg: shared constants, complex bin word and peak-detector FSM states.
package fft_pkg;
    localparam int N_POINTS = 64;
    localparam int DATA_W   = 16;
    localparam int MAG_W    = 2 * DATA_W;
    localparam int IDX_W    = $clog2(N_POINTS);

    typedef struct packed {
        logic signed [DATA_W-1:0] re;
        logic signed [DATA_W-1:0] im;
    } cplx_t;

    typedef enum logic [1:0] {IDLE, ACCUM, FLUSH} state_e;
endpackage

// File: rtl/fft_mag_sq.sv
// fft_mag_sq: 2-stage squared magnitude (square, then sum) with valid/last/idx sideband.
module fft_mag_sq
    import fft_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic             in_last,
    input  logic [IDX_W-1:0] in_idx,
    input  cplx_t            in_data,
    output logic             out_valid,
    output logic             out_last,
    output logic [IDX_W-1:0] out_idx,
    output logic [MAG_W-1:0] out_mag
);
    logic             r_v1, r_l1;
    logic [IDX_W-1:0] r_i1;
    logic [MAG_W-1:0] r_re2, r_im2;

    // Each square is at most 2^30, so their sum (at most 2^31) fits unsigned MAG_W.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_v1      <= 1'b0;
            r_l1      <= 1'b0;
            r_i1      <= '0;
            r_re2     <= '0;
            r_im2     <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_idx   <= '0;
            out_mag   <= '0;
        end else begin
            r_v1      <= in_valid;
            r_l1      <= in_valid && in_last;
            r_i1      <= in_idx;
            r_re2     <= in_data.re * in_data.re;
            r_im2     <= in_data.im * in_data.im;
            out_valid <= r_v1;
            out_last  <= r_l1;
            out_idx   <= r_i1;
            out_mag   <= r_re2 + r_im2;
        end
    end
endmodule

// File: rtl/fft_peak_detect.sv
// fft_peak_detect: tracks the strongest positive-frequency bin (DC excluded) of each
// FFT frame and reports its index/magnitude once the frame has drained.
module fft_peak_detect
    import fft_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [MAG_W-1:0] in_data,
    input  logic             in_last,
    input  logic [MAG_W-1:0] min_mag,
    output logic             peak_valid,
    output logic             peak_found,
    output logic [IDX_W-1:0] peak_idx,
    output logic [MAG_W-1:0] peak_mag,
    output logic             frame_err
);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_POINTS - 1);
    localparam logic [IDX_W-1:0] HALF_IDX = IDX_W'(N_POINTS / 2);

    state_e           r_state, w_state_nxt;
    logic             r_fl, r_full, r_err_pend;
    logic [IDX_W-1:0] r_cnt, r_best_idx;
    logic [MAG_W-1:0] r_best_mag;
    logic             w_acc, w_first, w_extra, w_elig, w_upd, w_found;
    logic [IDX_W-1:0] w_idx, w_best_idx;
    logic [MAG_W-1:0] w_best_mag;
    logic             w_s_valid, w_s_last;
    logic [IDX_W-1:0] w_s_idx;
    logic [MAG_W-1:0] w_s_mag;

    assign in_ready = (r_state != FLUSH);
    assign w_acc    = in_valid && in_ready;
    assign w_first  = (r_state == IDLE);
    assign w_idx    = w_first ? '0 : r_cnt;
    assign w_extra  = !w_first && r_full;

    always_comb begin
        w_state_nxt = r_state;
        if (r_state == FLUSH)
            w_state_nxt = r_fl ? IDLE : FLUSH;
        else if (w_acc)
            w_state_nxt = in_last ? FLUSH : ACCUM;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_fl       <= 1'b0;
            r_cnt      <= '0;
            r_full     <= 1'b0;
            r_err_pend <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_fl    <= (r_state == FLUSH) && !r_fl;
            if (w_acc) begin
                // Saturated words keep LAST_IDX, which is never eligible, so they are ignored.
                r_cnt  <= (w_idx == LAST_IDX) ? w_idx : w_idx + 1'b1;
                r_full <= w_extra || (w_idx == LAST_IDX);
                if (in_last)
                    r_err_pend <= w_extra || (w_idx != LAST_IDX);
            end
        end
    end

    fft_mag_sq u_mag (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (w_acc),
        .in_last   (in_last),
        .in_idx    (w_idx),
        .in_data   (cplx_t'(in_data)),
        .out_valid (w_s_valid),
        .out_last  (w_s_last),
        .out_idx   (w_s_idx),
        .out_mag   (w_s_mag)
    );

    assign w_elig     = w_s_valid && (w_s_idx != '0) && (w_s_idx < HALF_IDX);
    assign w_upd      = w_elig && (w_s_mag > r_best_mag);
    assign w_best_mag = w_upd ? w_s_mag : r_best_mag;
    assign w_best_idx = w_upd ? w_s_idx : r_best_idx;
    assign w_found    = (w_best_mag >= min_mag);

    // The result is taken from the compare's next value so the final bin is included.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_best_mag <= '0;
            r_best_idx <= '0;
            peak_valid <= 1'b0;
            peak_found <= 1'b0;
            peak_idx   <= '0;
            peak_mag   <= '0;
            frame_err  <= 1'b0;
        end else begin
            r_best_mag <= (w_acc && w_first) ? '0 : w_best_mag;
            r_best_idx <= (w_acc && w_first) ? '0 : w_best_idx;
            peak_valid <= w_s_valid && w_s_last;
            if (w_s_valid && w_s_last) begin
                peak_found <= w_found;
                peak_idx   <= w_found ? w_best_idx : '0;
                peak_mag   <= w_found ? w_best_mag : '0;
                frame_err  <= r_err_pend;
            end
        end
    end
endmodule

// File: tb/tb_fft_peak_detect.sv
// tb_fft_peak_detect: randomized scoreboard bench; a frame-level model predicts each peak result.
module tb_fft_peak_detect;
    import fft_pkg::*;

    logic        clk = 1'b0, reset = 1'b0, in_valid = 1'b0, in_last = 1'b0;
    logic [31:0] in_data = '0, min_mag = '0;
    logic        in_ready, peak_valid, peak_found, frame_err;
    logic [5:0]  peak_idx;
    logic [31:0] peak_mag;

    typedef struct {
        bit        found;
        bit [5:0]  idx;
        bit [31:0] mag;
        bit        err;
    } res_t;

    res_t        exp_q[$];
    res_t        e;
    logic [31:0] frame[$];
    int          tests = 0, fails = 0;

    always #5 clk = ~clk;

    fft_peak_detect dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_last    (in_last),
        .min_mag    (min_mag),
        .peak_valid (peak_valid),
        .peak_found (peak_found),
        .peak_idx   (peak_idx),
        .peak_mag   (peak_mag),
        .frame_err  (frame_err)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] cw(input int re, input int im);
        return {re[15:0], im[15:0]};
    endfunction

    // Peak over the first N_POINTS words, bins 1..N/2-1 only, first maximum wins.
    function automatic res_t model(input logic [31:0] mm);
        res_t   r;
        longint best = 0, re, im, mag;
        int     bi = 0;
        for (int i = 0; i < frame.size() && i < N_POINTS; i++) begin
            re  = $signed(frame[i][31:16]);
            im  = $signed(frame[i][15:0]);
            mag = re * re + im * im;
            if (i > 0 && i < N_POINTS / 2 && mag > best) begin
                best = mag;
                bi   = i;
            end
        end
        r.found = (best >= longint'(mm));
        r.idx   = r.found ? 6'(bi) : 6'd0;
        r.mag   = r.found ? best[31:0] : 32'd0;
        r.err   = (frame.size() != N_POINTS);
        return r;
    endfunction

    task automatic zero(input int n);
        frame.delete();
        repeat (n) frame.push_back(32'd0);
    endtask

    task automatic send(input logic [31:0] mm, input int gap);
        int n;
        min_mag = mm;
        exp_q.push_back(model(mm));
        for (int i = 0; i < frame.size(); i++) begin
            while ($urandom_range(99) < gap) begin
                in_valid = 1'b0;
                @(negedge clk);
            end
            in_valid = 1'b1;
            in_data  = frame[i];
            in_last  = (i == frame.size() - 1);
            n = 0;
            while (!in_ready && n < 10) begin
                @(negedge clk);
                n++;
            end
            if (!in_ready) chk("ready_timeout", in_ready, 1);
            @(negedge clk);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        chk("flush_ready_c1", in_ready, 0);
        @(negedge clk);
        chk("flush_ready_c2", in_ready, 0);
        @(negedge clk);
        chk("ready_after_flush", in_ready, 1);
        chk("peak_valid_latency", peak_valid, 1);
    endtask

    always @(negedge clk) begin
        if (peak_valid) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_peak_valid: got 1 expected 0 at %0t", $time);
            end else begin
                e = exp_q.pop_front();
                chk("peak_found", peak_found, e.found);
                chk("peak_idx", peak_idx, e.idx);
                chk("peak_mag", peak_mag, e.mag);
                chk("frame_err", frame_err, e.err);
            end
        end
    end

    initial begin
        int n, len;
        logic [31:0] mm;
        repeat (2) @(negedge clk);
        chk("rst_ready", in_ready, 1);
        chk("rst_valid", peak_valid, 0);
        chk("rst_found", peak_found, 0);
        chk("rst_idx", peak_idx, 0);
        chk("rst_mag", peak_mag, 0);
        chk("rst_err", frame_err, 0);
        reset = 1'b1;
        @(negedge clk);

        zero(64); frame[5] = cw(1000, 0); send(0, 0);
        zero(64); frame[3] = cw(300, 400); frame[7] = cw(300, 400); send(0, 0);
        zero(64); frame[0] = cw(32767, 0); frame[40] = cw(32767, 0); frame[10] = cw(100, 100);
        send(0, 40);
        zero(64); frame[12] = cw(-32768, -32768); send(32'h8000_0001, 0); send(0, 0);
        zero(70); frame[15] = cw(500, -7); send(0, 10);
        zero(40); frame[20] = cw(-1234, 55); send(0, 0);
        zero(64); send(0, 0);

        zero(64); frame[3] = cw(5000, 5000);
        for (int i = 0; i < 30; i++) begin
            in_valid = 1'b1;
            in_data  = frame[i];
            @(negedge clk);
        end
        in_valid = 1'b0;
        #2 reset = 1'b0;
        #1;
        chk("midrst_ready", in_ready, 1);
        chk("midrst_valid", peak_valid, 0);
        chk("midrst_found", peak_found, 0);
        chk("midrst_idx", peak_idx, 0);
        chk("midrst_mag", peak_mag, 0);
        chk("midrst_err", frame_err, 0);
        @(negedge clk);
        reset = 1'b1;
        repeat (5) @(negedge clk);
        zero(64); frame[9] = cw(-200, 300); send(0, 20);

        repeat (20) begin
            len = ($urandom_range(4) == 0) ? $urandom_range(1, 80) : 64;
            frame.delete();
            for (int i = 0; i < len; i++)
                frame.push_back($urandom_range(1) ? $urandom : cw($urandom_range(0, 2000) - 1000, $urandom_range(0, 2000) - 1000));
            case ($urandom_range(2))
                0: mm = 0;
                1: mm = $urandom;
                default: mm = $urandom_range(0, 1 << 20);
            endcase
            send(mm, $urandom_range(0, 30));
        end

        n = 0;
        while (exp_q.size() > 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("scoreboard_drained", 32'(exp_q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
